// File: rtl/dma_link_sequencer_tx.sv
`default_nettype none
// ============================================================================
// Module : dma_link_sequencer_tx
// Brief  : TX DMA link register bank with a descriptor sequencer that feeds
//          the TX engine. Optional macro DMA_SEQ_IRQ_EN adds the done irq.
// Rev    : 1.0 - initial release
// ============================================================================
module dma_link_sequencer_tx #(
  parameter int                DATA_W    = 64,
  parameter int                ADDR_W    = 32,
  parameter int                NUM_LINKS = 16,
  parameter logic [ADDR_W-1:0] REG_BASE  = 32'hFFFF_0000,
  parameter int                IDX_W     = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] slave_addr_i,
  input  logic [DATA_W-1:0] slave_data_i,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              desc_valid_o,
  input  logic              desc_ready_i,
  output logic [DATA_W-1:0] desc_data_o,
  output logic [DATA_W-1:0] desc_base_o,
  output logic [IDX_W-1:0]  desc_idx_o,
  input  logic              xfer_done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o,
  output logic              irq_o
);

  localparam int                c_stride    = DATA_W / 8;
  localparam logic [ADDR_W-1:0] c_ctrl_addr = REG_BASE + ADDR_W'((NUM_LINKS + 1) * c_stride);
  localparam logic [ADDR_W-1:0] c_stat_addr = REG_BASE + ADDR_W'((NUM_LINKS + 2) * c_stride);
  localparam logic [7:0]        c_max_cnt   = 8'(NUM_LINKS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   base_q;
  logic [DATA_W-1:0]   link_q [NUM_LINKS];
  logic [7:0]          count_q;
  logic [IDX_W-1:0]    idx_q;
  logic                desc_valid_q, busy_q, done_q, aborted_q, abort_pend_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;

  logic                w_wr_base, w_wr_ctrl, w_wr_link;
  logic [IDX_W-1:0]    w_wr_idx;
  logic [DATA_W-1:0]   w_rd_val;
  logic [31:0]         w_status;
  logic                w_start, w_abort, w_irq_clr, w_cnt_ok, w_last, w_irq;
  logic [7:0]          w_cnt;

  always_comb begin
    w_wr_base = wr_en_i && (slave_addr_i == REG_BASE);
    w_wr_ctrl = wr_en_i && (slave_addr_i == c_ctrl_addr);
    w_wr_link = 1'b0;
    w_wr_idx  = '0;
    for (int i = 0; i < NUM_LINKS; i++) begin
      if (slave_addr_i == REG_BASE + ADDR_W'((i + 1) * c_stride)) begin
        w_wr_link = wr_en_i;
        w_wr_idx  = IDX_W'(i);
      end
    end
  end

  assign w_status = {8'h00, 8'(idx_q), count_q, 5'b0, w_irq, aborted_q, busy_q};

  // CTRL is write-only and reads back as zero like any unmapped slot.
  always_comb begin
    w_rd_val = '0;
    if (rd_addr_i == REG_BASE)    w_rd_val = base_q;
    if (rd_addr_i == c_stat_addr) w_rd_val = DATA_W'(w_status);
    for (int i = 0; i < NUM_LINKS; i++) begin
      if (rd_addr_i == REG_BASE + ADDR_W'((i + 1) * c_stride)) w_rd_val = link_q[i];
    end
  end

  assign w_cnt     = slave_data_i[15:8];
  assign w_start   = w_wr_ctrl && slave_data_i[0];
  assign w_abort   = w_wr_ctrl && slave_data_i[1];
  assign w_irq_clr = w_wr_ctrl && slave_data_i[2];
  assign w_cnt_ok  = (w_cnt != 8'd0) && (w_cnt <= c_max_cnt);
  assign w_last    = (8'(idx_q) == count_q - 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < NUM_LINKS; i++) link_q[i] <= '0;
    end else if (!busy_q) begin
      if (w_wr_base) base_q <= slave_data_i;
      if (w_wr_link) link_q[w_wr_idx] <= slave_data_i;
      if (w_wr_ctrl) count_q <= w_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) rd_data_q <= w_rd_val;
    end
  end

  // FIN is entered with busy already low so done and !busy coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      desc_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_start && w_cnt_ok) begin
            idx_q        <= '0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            desc_valid_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_abort) abort_pend_q <= 1'b1;
          if (desc_ready_i) begin
            desc_valid_q <= 1'b0;
            if (abort_pend_q || w_abort) begin
              aborted_q    <= 1'b1;
              abort_pend_q <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              state_q      <= S_FIN;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (w_abort) begin
            aborted_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_FIN;
          end else if (xfer_done_i) begin
            if (w_last) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              idx_q        <= idx_q + IDX_W'(1);
              desc_valid_q <= 1'b1;
              state_q      <= S_ISSUE;
            end
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef DMA_SEQ_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk) begin
    if (rst)            irq_q <= 1'b0;
    else if (done_q)    irq_q <= 1'b1;
    else if (w_irq_clr) irq_q <= 1'b0;
  end
  assign w_irq = irq_q;
`else
  logic w_unused_irq_clr;
  assign w_unused_irq_clr = w_irq_clr;
  assign w_irq            = 1'b0;
`endif

  assign rd_data_o    = rd_data_q;
  assign rd_valid_o   = rd_valid_q;
  assign desc_valid_o = desc_valid_q;
  assign desc_data_o  = link_q[idx_q];
  assign desc_base_o  = base_q;
  assign desc_idx_o   = idx_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign aborted_o    = aborted_q;
  assign irq_o        = w_irq;

endmodule
`default_nettype wire

// File: tb/tb_dma_link_sequencer_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_dma_link_sequencer_tx
// Brief  : Randomised self-checking bench; acts as bus master and TX engine.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dma_link_sequencer_tx;
  localparam int          DW = 64;
  localparam int          AW = 32;
  localparam int          NL = 16;
  localparam int          IW = 4;
  localparam logic [31:0] RB     = 32'hFFFF_0000;
  localparam logic [31:0] A_CTRL = RB + 32'd136;
  localparam logic [31:0] A_STAT = RB + 32'd144;
`ifdef DMA_SEQ_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] slave_addr = '0, rd_addr = '0;
  logic [DW-1:0] slave_data = '0;
  logic          wr_en = 1'b0, rd_en = 1'b0, desc_ready = 1'b0, xfer_done = 1'b0;
  logic [DW-1:0] rd_data, desc_data, desc_base;
  logic [IW-1:0] desc_idx;
  logic          rd_valid, desc_valid, busy, done, aborted, irq;

  always #5 clk = ~clk;

  dma_link_sequencer_tx #(.DATA_W(DW), .ADDR_W(AW), .NUM_LINKS(NL), .REG_BASE(RB)) dut (
    .clk(clk), .rst(rst), .slave_addr_i(slave_addr), .slave_data_i(slave_data),
    .wr_en_i(wr_en), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .rd_valid_o(rd_valid), .desc_valid_o(desc_valid), .desc_ready_i(desc_ready),
    .desc_data_o(desc_data), .desc_base_o(desc_base), .desc_idx_o(desc_idx),
    .xfer_done_i(xfer_done), .busy_o(busy), .done_o(done), .aborted_o(aborted), .irq_o(irq)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: register contents plus sequence-level status.
  logic [63:0] m_base;
  logic [63:0] m_link [NL];
  logic [7:0]  m_count;
  int          m_idx;
  bit          m_aborted, m_irq, m_busy;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] a_link(input int i);
    return RB + 32'((i + 1) * 8);
  endfunction

  function automatic logic [63:0] exp_read(input logic [31:0] addr);
    logic [63:0] r;
    r = '0;
    if (addr == RB) r = m_base;
    if (addr == A_STAT) r = {40'b0, 8'(m_idx), m_count, 5'b0, m_irq, m_aborted, m_busy};
    for (int i = 0; i < NL; i++) if (addr == a_link(i)) r = m_link[i];
    return r;
  endfunction

  task automatic model_reset();
    m_base = '0; m_count = '0; m_idx = 0;
    m_aborted = 0; m_irq = 0; m_busy = 0;
    for (int i = 0; i < NL; i++) m_link[i] = '0;
  endtask

  task automatic m_write(input logic [31:0] addr, input logic [63:0] data);
    if (!m_busy) begin
      if (addr == RB) m_base = data;
      for (int i = 0; i < NL; i++) if (addr == a_link(i)) m_link[i] = data;
      if (addr == A_CTRL) m_count = data[15:8];
    end
    if (addr == A_CTRL && data[2]) m_irq = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [63:0] data);
    slave_addr = addr; slave_data = data; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    m_write(addr, data);
  endtask

  task automatic bus_read(input string tag, input logic [31:0] addr);
    logic [63:0] e;
    e = exp_read(addr);
    rd_addr = addr; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_val({tag, "_vld"}, 64'(rd_valid), 64'd1);
    check_val(tag, rd_data, e);
  endtask

  task automatic finish_seq();
    check_val("done_pulse", 64'(done), 64'd1);
    check_val("busy_at_done", 64'(busy), 64'd0);
    check_val("aborted_flag", 64'(aborted), 64'(m_aborted));
    check_val("valid_at_done", 64'(desc_valid), 64'd0);
    m_busy = 0;
    tick();
    check_val("done_one_cycle", 64'(done), 64'd0);
    if (IRQ_ON) m_irq = 1;
    check_val("irq_after_done", 64'(irq), 64'(m_irq));
  endtask

  // mode: 0 none, 1 abort while ISSUE at link ak, 2 abort while WAIT at link ak
  task automatic run_seq(input int cnt, input int mode, input int ak);
    int stall, dly;
    bit ended;
    ended = 0;
    slave_addr = A_CTRL; slave_data = {48'b0, 8'(cnt), 8'h01}; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    m_count = 8'(cnt); m_idx = 0; m_aborted = 0; m_busy = 1;
    check_val("start_busy", 64'(busy), 64'd1);
    for (int k = 0; k < cnt && !ended; k++) begin
      m_idx = k;
      check_val("desc_valid", 64'(desc_valid), 64'd1);
      check_val("desc_idx", 64'(desc_idx), 64'(k));
      check_val("desc_data", desc_data, m_link[k]);
      check_val("desc_base", desc_base, m_base);
      stall = $urandom_range(0, 3);
      if (mode == 1 && k == ak && stall == 0) stall = 1;
      for (int s = 0; s < stall; s++) begin
        if (mode == 1 && k == ak && s == 0) begin
          slave_addr = A_CTRL; slave_data = 64'h2; wr_en = 1'b1;
        end
        tick();
        wr_en = 1'b0;
        check_val("stall_valid", 64'(desc_valid), 64'd1);
        check_val("stall_idx", 64'(desc_idx), 64'(k));
        check_val("stall_data", desc_data, m_link[k]);
      end
      desc_ready = 1'b1;
      tick();
      desc_ready = 1'b0;
      check_val("hs_drop", 64'(desc_valid), 64'd0);
      if (mode == 1 && k == ak) begin
        m_aborted = 1;
        finish_seq();
        ended = 1;
      end else begin
        if (k == 0 && !(mode == 2 && ak == 0)) begin
          bus_write(a_link(0), 64'hFFFF);
          bus_write(A_CTRL, {48'b0, 8'(NL), 8'h01});
          check_val("restart_ign_busy", 64'(busy), 64'd1);
          check_val("restart_ign_valid", 64'(desc_valid), 64'd0);
          bus_read("stat_busy", A_STAT);
        end
        dly = $urandom_range(0, 2);
        for (int d = 0; d < dly; d++) begin
          tick();
          check_val("wait_quiet", 64'(desc_valid), 64'd0);
          check_val("wait_busy", 64'(busy), 64'd1);
        end
        if (mode == 2 && k == ak) begin
          xfer_done = 1'($urandom_range(0, 1));
          slave_addr = A_CTRL; slave_data = 64'h2; wr_en = 1'b1;
          tick();
          wr_en = 1'b0; xfer_done = 1'b0;
          m_aborted = 1;
          finish_seq();
          ended = 1;
        end else begin
          xfer_done = 1'b1;
          tick();
          xfer_done = 1'b0;
          if (k == cnt - 1) begin
            finish_seq();
            ended = 1;
          end
        end
      end
    end
  endtask

  initial begin
    int cnt, mode, ak;
    model_reset();
    repeat (3) tick();
    check_val("rst_rd_valid", 64'(rd_valid), 64'd0);
    check_val("rst_rd_data", rd_data, 64'd0);
    check_val("rst_desc_valid", 64'(desc_valid), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_aborted", 64'(aborted), 64'd0);
    check_val("rst_irq", 64'(irq), 64'd0);
    rst = 1'b0;
    tick();

    bus_read("rd_base", RB);
    for (int i = 0; i < NL; i++) bus_read("rd_link", a_link(i));
    bus_read("rd_ctrl", A_CTRL);
    bus_read("rd_status", A_STAT);
    bus_read("rd_unmapped_hi", RB + 32'd152);
    bus_read("rd_unmapped_mis", RB + 32'd4);
    tick();
    check_val("rd_valid_drop", 64'(rd_valid), 64'd0);

    slave_addr = a_link(3); slave_data = 64'hDEAD_BEEF_0000_0003; wr_en = 1'b0;
    tick();
    bus_read("wr_en_gate", a_link(3));
    bus_write(a_link(3), 64'hDEAD_BEEF_0000_0003);
    bus_read("link3_wb", a_link(3));

    bus_write(RB, 64'h1000);
    for (int i = 0; i < 3; i++) bus_write(a_link(i), {$urandom, $urandom});
    run_seq(3, 0, 0);
    bus_read("link0_after_busy_wr", a_link(0));
    bus_read("stat_after_seq", A_STAT);

    bus_write(A_CTRL, 64'h0001);
    check_val("cnt0_idle", 64'(busy), 64'd0);
    tick();
    check_val("cnt0_novalid", 64'(desc_valid), 64'd0);
    bus_write(A_CTRL, 64'h1101);
    check_val("cnt17_idle", 64'(busy), 64'd0);
    bus_read("stat_cnt17", A_STAT);

    for (int it = 0; it < 12; it++) begin
      bus_write(RB, {$urandom, $urandom});
      for (int i = 0; i < NL; i++) bus_write(a_link(i), {$urandom, $urandom});
      cnt  = $urandom_range(1, NL);
      mode = (it < 3) ? it : $urandom_range(0, 2);
      ak   = $urandom_range(0, cnt - 1);
      run_seq(cnt, mode, ak);
      bus_read("stat_rand", A_STAT);
      bus_read("link_rand", a_link($urandom_range(0, NL - 1)));
      bus_write(A_CTRL, {48'b0, m_count, 8'h02});
      check_val("idle_abort_noeffect", 64'(aborted), 64'(m_aborted));
      if ($urandom_range(0, 1) == 1) begin
        bus_write(A_CTRL, {48'b0, m_count, 8'h04});
        check_val("irq_clr", 64'(irq), 64'(m_irq));
        bus_read("stat_irq_clr", A_STAT);
      end
    end

    bus_write(A_CTRL, {48'b0, 8'd4, 8'h01});
    tick();
    check_val("midrst_valid_pre", 64'(desc_valid), 64'd1);
    rst = 1'b1;
    tick();
    model_reset();
    check_val("midrst_busy", 64'(busy), 64'd0);
    check_val("midrst_valid", 64'(desc_valid), 64'd0);
    check_val("midrst_done", 64'(done), 64'd0);
    check_val("midrst_irq", 64'(irq), 64'd0);
    rst = 1'b0;
    tick();
    check_val("midrst_no_done", 64'(done), 64'd0);
    bus_read("midrst_stat", A_STAT);
    bus_read("midrst_link", a_link(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
